// File: rtl/storage_load_pkg.sv
// Shared encodings and default widths for the storage load sequencer.
package storage_load_pkg;

  localparam int unsigned DEF_DATA_W           = 48;
  localparam int unsigned DEF_CODE_W           = 12;
  localparam int unsigned DEF_IDX_W            = 32;
  localparam int unsigned DEF_LOC_RESET_CYCLES = 2;
  localparam int unsigned DEF_WATCHDOG_W       = 16;

  localparam int unsigned TGT_W = 3;
  localparam logic [TGT_W-1:0] TGT_CODE   = 3'd0;
  localparam logic [TGT_W-1:0] TGT_WEIGHT = 3'd1;
  localparam logic [TGT_W-1:0] TGT_INPUT  = 3'd2;
  localparam logic [TGT_W-1:0] TGT_LABEL  = 3'd3;
  localparam logic [TGT_W-1:0] TGT_START  = 3'd4;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_LRST = 2'd1;
  localparam logic [ST_W-1:0] ST_ARM  = 2'd2;
  localparam logic [ST_W-1:0] ST_RUN  = 2'd3;

endpackage

// File: rtl/storage_load_sequencer_seq_watchdog.sv
// Run watchdog: free-running counter with synchronous clear and terminal count at all-ones.
module seq_watchdog #(
  parameter int unsigned W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_tc_c = &r_count;

endmodule

// File: rtl/storage_load_sequencer.sv
// Host loader and run sequencer: turns commands into storage writes and
// sequences locator reset, code-storage arm and controller run.
module storage_load_sequencer
  import storage_load_pkg::*;
#(
  parameter int unsigned DATA_W           = DEF_DATA_W,
  parameter int unsigned CODE_W           = DEF_CODE_W,
  parameter int unsigned IDX_W            = DEF_IDX_W,
  parameter int unsigned LOC_RESET_CYCLES = DEF_LOC_RESET_CYCLES,
  parameter int unsigned WATCHDOG_W       = DEF_WATCHDOG_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [TGT_W-1:0]  cmd_target,
  input  logic [IDX_W-1:0]  cmd_layer,
  input  logic [IDX_W-1:0]  cmd_row,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [IDX_W-1:0]  code_index,
  output logic              code_is_write,
  output logic [IDX_W-1:0]  code_write_line,
  output logic [CODE_W-1:0] code_write_data,
  output logic              wt_is_write,
  output logic              in_is_write,
  output logic              lb_is_write,
  output logic [IDX_W-1:0]  st_write_layer,
  output logic [IDX_W-1:0]  st_write_row,
  output logic [DATA_W-1:0] st_write_data,
  output logic              code_storage_enable,
  output logic              controller_enable,
  output logic              matrix_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  // Code count is one bit wider so a write to the last line still counts.
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned LRST_W = (LOC_RESET_CYCLES > 1) ? $clog2(LOC_RESET_CYCLES) : 1;
  localparam logic [LRST_W-1:0] LRST_LAST = LRST_W'(LOC_RESET_CYCLES - 1);

  logic [ST_W-1:0]   r_state, w_state_nxt;
  logic [LRST_W-1:0] r_lrst_cnt, w_lrst_cnt_nxt;
  logic [CNT_W-1:0]  r_code_count, w_code_count_nxt;

  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_code_is_write, w_code_is_write_nxt;
  logic [IDX_W-1:0]  r_code_write_line, w_code_write_line_nxt;
  logic [CODE_W-1:0] r_code_write_data, w_code_write_data_nxt;
  logic              r_wt_is_write, w_wt_is_write_nxt;
  logic              r_in_is_write, w_in_is_write_nxt;
  logic              r_lb_is_write, w_lb_is_write_nxt;
  logic [IDX_W-1:0]  r_st_write_layer, w_st_write_layer_nxt;
  logic [IDX_W-1:0]  r_st_write_row, w_st_write_row_nxt;
  logic [DATA_W-1:0] r_st_write_data, w_st_write_data_nxt;
  logic              r_code_en, w_code_en_nxt;
  logic              r_ctrl_en, w_ctrl_en_nxt;
  logic              r_matrix_reset, w_matrix_reset_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;

  logic              w_accept;
  logic [CNT_W-1:0]  w_row_plus1;
  logic              w_run_end;
  logic              w_wd_clr;
  logic              w_wd_en;
  logic              w_wd_tc;

  assign w_accept    = cmd_valid & r_cmd_ready;
  assign w_row_plus1 = CNT_W'(cmd_row) + CNT_W'(1);
  assign w_run_end   = ({1'b0, code_index} >= r_code_count);

  // Counting through ARM gives the controller 2^W-1 enabled cycles before timeout.
  seq_watchdog #(
    .W (WATCHDOG_W)
  ) u_watchdog (
    .clk    (clk_clk),
    .rst_n  (reset_reset_n),
    .i_clr  (w_wd_clr),
    .i_en   (w_wd_en),
    .o_tc_c (w_wd_tc)
  );

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt           = r_state;
    w_lrst_cnt_nxt        = r_lrst_cnt;
    w_code_count_nxt      = r_code_count;
    w_cmd_ready_nxt       = r_cmd_ready;
    w_code_is_write_nxt   = 1'b0;
    w_code_write_line_nxt = r_code_write_line;
    w_code_write_data_nxt = r_code_write_data;
    w_wt_is_write_nxt     = 1'b0;
    w_in_is_write_nxt     = 1'b0;
    w_lb_is_write_nxt     = 1'b0;
    w_st_write_layer_nxt  = r_st_write_layer;
    w_st_write_row_nxt    = r_st_write_row;
    w_st_write_data_nxt   = r_st_write_data;
    w_code_en_nxt         = r_code_en;
    w_ctrl_en_nxt         = r_ctrl_en;
    w_matrix_reset_nxt    = r_matrix_reset;
    w_done_nxt            = 1'b0;
    w_error_nxt           = r_error;
    w_wd_clr              = 1'b0;
    w_wd_en               = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (w_accept) begin
          case (cmd_target)
            TGT_CODE: begin
              w_code_is_write_nxt   = 1'b1;
              w_code_write_line_nxt = cmd_row;
              w_code_write_data_nxt = cmd_data[CODE_W-1:0];
              if (w_row_plus1 > r_code_count) begin
                w_code_count_nxt = w_row_plus1;
              end
            end
            TGT_WEIGHT, TGT_INPUT, TGT_LABEL: begin
              w_wt_is_write_nxt    = (cmd_target == TGT_WEIGHT);
              w_in_is_write_nxt    = (cmd_target == TGT_INPUT);
              w_lb_is_write_nxt    = (cmd_target == TGT_LABEL);
              w_st_write_layer_nxt = cmd_layer;
              w_st_write_row_nxt   = cmd_row;
              w_st_write_data_nxt  = cmd_data;
            end
            TGT_START: begin
              if (r_code_count == '0) begin
                w_error_nxt = 1'b1;
              end else begin
                w_error_nxt        = 1'b0;
                w_state_nxt        = ST_LRST;
                w_lrst_cnt_nxt     = '0;
                w_cmd_ready_nxt    = 1'b0;
                w_matrix_reset_nxt = 1'b1;
              end
            end
            default: begin
              w_error_nxt = 1'b1;
            end
          endcase
        end
      end

      ST_LRST: begin
        if (r_lrst_cnt == LRST_LAST) begin
          w_state_nxt        = ST_ARM;
          w_matrix_reset_nxt = 1'b0;
          w_code_en_nxt      = 1'b1;
          w_wd_clr           = 1'b1;
        end else begin
          w_lrst_cnt_nxt = r_lrst_cnt + LRST_W'(1);
        end
      end

      ST_ARM: begin
        w_wd_en       = 1'b1;
        w_state_nxt   = ST_RUN;
        w_ctrl_en_nxt = 1'b1;
      end

      ST_RUN: begin
        w_wd_en = 1'b1;
        // A normal end takes priority over a coincident timeout.
        if (w_run_end || w_wd_tc) begin
          w_done_nxt      = w_run_end;
          w_error_nxt     = r_error | ~w_run_end;
          w_code_en_nxt   = 1'b0;
          w_ctrl_en_nxt   = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt     = ST_IDLE;
        w_cmd_ready_nxt = 1'b1;
        w_code_en_nxt   = 1'b0;
        w_ctrl_en_nxt   = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state           <= ST_IDLE;
      r_lrst_cnt        <= '0;
      r_code_count      <= '0;
      r_cmd_ready       <= 1'b1;
      r_code_is_write   <= 1'b0;
      r_code_write_line <= '0;
      r_code_write_data <= '0;
      r_wt_is_write     <= 1'b0;
      r_in_is_write     <= 1'b0;
      r_lb_is_write     <= 1'b0;
      r_st_write_layer  <= '0;
      r_st_write_row    <= '0;
      r_st_write_data   <= '0;
      r_code_en         <= 1'b0;
      r_ctrl_en         <= 1'b0;
      r_matrix_reset    <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_error           <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_lrst_cnt        <= w_lrst_cnt_nxt;
      r_code_count      <= w_code_count_nxt;
      r_cmd_ready       <= w_cmd_ready_nxt;
      r_code_is_write   <= w_code_is_write_nxt;
      r_code_write_line <= w_code_write_line_nxt;
      r_code_write_data <= w_code_write_data_nxt;
      r_wt_is_write     <= w_wt_is_write_nxt;
      r_in_is_write     <= w_in_is_write_nxt;
      r_lb_is_write     <= w_lb_is_write_nxt;
      r_st_write_layer  <= w_st_write_layer_nxt;
      r_st_write_row    <= w_st_write_row_nxt;
      r_st_write_data   <= w_st_write_data_nxt;
      r_code_en         <= w_code_en_nxt;
      r_ctrl_en         <= w_ctrl_en_nxt;
      r_matrix_reset    <= w_matrix_reset_nxt;
      r_busy            <= w_busy_nxt;
      r_done            <= w_done_nxt;
      r_error           <= w_error_nxt;
    end
  end

  assign cmd_ready           = r_cmd_ready;
  assign code_is_write       = r_code_is_write;
  assign code_write_line     = r_code_write_line;
  assign code_write_data     = r_code_write_data;
  assign wt_is_write         = r_wt_is_write;
  assign in_is_write         = r_in_is_write;
  assign lb_is_write         = r_lb_is_write;
  assign st_write_layer      = r_st_write_layer;
  assign st_write_row        = r_st_write_row;
  assign st_write_data       = r_st_write_data;
  assign code_storage_enable = r_code_en;
  assign controller_enable   = r_ctrl_en;
  assign matrix_reset        = r_matrix_reset;
  assign busy                = r_busy;
  assign done                = r_done;
  assign error               = r_error;

endmodule

// File: tb/tb_storage_load_sequencer.sv
// Randomized bench for storage_load_sequencer against a command-level reference model.
module tb_storage_load_sequencer;

  localparam int unsigned DATA_W = 48;
  localparam int unsigned CODE_W = 12;
  localparam int unsigned IDX_W  = 32;
  localparam int unsigned LRST   = 2;
  localparam int unsigned WD_W   = 4;
  localparam int          WD_MAX = (1 << WD_W) - 1;

  logic              clk_clk;
  logic              reset_reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_target;
  logic [IDX_W-1:0]  cmd_layer;
  logic [IDX_W-1:0]  cmd_row;
  logic [DATA_W-1:0] cmd_data;
  logic [IDX_W-1:0]  code_index;
  logic              code_is_write;
  logic [IDX_W-1:0]  code_write_line;
  logic [CODE_W-1:0] code_write_data;
  logic              wt_is_write, in_is_write, lb_is_write;
  logic [IDX_W-1:0]  st_write_layer;
  logic [IDX_W-1:0]  st_write_row;
  logic [DATA_W-1:0] st_write_data;
  logic              code_storage_enable, controller_enable, matrix_reset;
  logic              busy, done, error;

  storage_load_sequencer #(
    .DATA_W(DATA_W), .CODE_W(CODE_W), .IDX_W(IDX_W),
    .LOC_RESET_CYCLES(LRST), .WATCHDOG_W(WD_W)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_layer(cmd_layer), .cmd_row(cmd_row), .cmd_data(cmd_data),
    .code_index(code_index),
    .code_is_write(code_is_write), .code_write_line(code_write_line),
    .code_write_data(code_write_data),
    .wt_is_write(wt_is_write), .in_is_write(in_is_write), .lb_is_write(lb_is_write),
    .st_write_layer(st_write_layer), .st_write_row(st_write_row),
    .st_write_data(st_write_data),
    .code_storage_enable(code_storage_enable), .controller_enable(controller_enable),
    .matrix_reset(matrix_reset), .busy(busy), .done(done), .error(error)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: program length, sticky error, last written payloads.
  longint unsigned   m_code_count;
  bit                m_error;
  logic [IDX_W-1:0]  m_line;
  logic [CODE_W-1:0] m_cdata;
  logic [IDX_W-1:0]  m_layer, m_row;
  logic [DATA_W-1:0] m_sdata;

  // {ready, code_w, wt_w, in_w, lb_w, code_en, ctrl_en, matrix_reset, busy, done, error}
  function automatic logic [10:0] ctl();
    return {cmd_ready, code_is_write, wt_is_write, in_is_write, lb_is_write,
            code_storage_enable, controller_enable, matrix_reset, busy, done, error};
  endfunction

  // Model of one idle-cycle command; returns the control vector expected one cycle later.
  function automatic logic [10:0] model_idle(input bit v, input logic [2:0] t,
                                             input logic [IDX_W-1:0] layer,
                                             input logic [IDX_W-1:0] row,
                                             input logic [DATA_W-1:0] data);
    logic [10:0] e;
    e = 11'h400;
    if (v) begin
      case (t)
        3'd0: begin
          e[9] = 1'b1; m_line = row; m_cdata = data[CODE_W-1:0];
          if (64'(row) + 64'd1 > m_code_count) m_code_count = 64'(row) + 64'd1;
        end
        3'd1, 3'd2, 3'd3: begin
          e[9 - int'(t)] = 1'b1; m_layer = layer; m_row = row; m_sdata = data;
        end
        3'd4: m_error = (m_code_count == 0);
        default: m_error = 1'b1;
      endcase
    end
    e[0] = m_error;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic model_reset();
    m_code_count = 0; m_error = 0;
    m_line = '0; m_cdata = '0; m_layer = '0; m_row = '0; m_sdata = '0;
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0; code_index = '0;
    reset_reset_n = 1'b0;
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input bit v, input logic [2:0] t, input logic [IDX_W-1:0] layer,
                       input logic [IDX_W-1:0] row, input logic [DATA_W-1:0] data);
    cmd_valid = v; cmd_target = t; cmd_layer = layer; cmd_row = row; cmd_data = data;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    @(posedge clk_clk);
    #1;
    model_reset();
    n_checks++;
    if (ctl() !== 11'h400) $display("FAIL reset_ctl got %b want %b", ctl(), 11'h400);
    else n_pass++;
    n_checks++;
    if ({code_write_line, code_write_data, st_write_layer, st_write_row, st_write_data} !== '0)
      $display("FAIL reset_data got %h want 0", {code_write_line, st_write_layer, st_write_row});
    else n_pass++;
    reset_reset_n = 1'b1;
    tick();
    n_checks++;
    if (ctl() !== 11'h400) $display("FAIL reset_idle got %b want %b", ctl(), 11'h400);
    else n_pass++;
  endtask

  task automatic test_code_writes();
    logic [10:0] e;
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = DATA_W'({$urandom(), $urandom()});
      drive(1'b1, 3'd0, $urandom(), IDX_W'(i), d);
      e = model_idle(1'b1, 3'd0, cmd_layer, cmd_row, d);
      tick();
      n_checks++;
      if (ctl() !== e) $display("FAIL code_wr%0d ctl got %b want %b", i, ctl(), e);
      else n_pass++;
      n_checks++;
      if ({code_write_line, code_write_data} !== {m_line, m_cdata})
        $display("FAIL code_wr%0d data got %h/%h want %h/%h", i,
                 code_write_line, code_write_data, m_line, m_cdata);
      else n_pass++;
    end
    cmd_valid = 1'b0;
    e = model_idle(1'b0, 3'd0, '0, '0, '0);
    tick();
    n_checks++;
    if (ctl() !== e) $display("FAIL code_wr_idle ctl got %b want %b", ctl(), e);
    else n_pass++;
  endtask

  task automatic test_weight_label();
    logic [10:0] e;
    drive(1'b1, 3'd1, 32'd1, 32'd2, 48'h0001_0002_0003);
    e = model_idle(1'b1, 3'd1, 32'd1, 32'd2, 48'h0001_0002_0003);
    tick();
    n_checks++;
    if (ctl() !== e || {st_write_layer, st_write_row, st_write_data} !== {m_layer, m_row, m_sdata})
      $display("FAIL weight_wr got %b %h/%h/%h want %b %h/%h/%h", ctl(), st_write_layer,
               st_write_row, st_write_data, e, m_layer, m_row, m_sdata);
    else n_pass++;
    drive(1'b1, 3'd3, 32'd0, 32'd5, 48'hABCD_0000_1234);
    e = model_idle(1'b1, 3'd3, 32'd0, 32'd5, 48'hABCD_0000_1234);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (ctl() !== e || {st_write_layer, st_write_row, st_write_data} !== {m_layer, m_row, m_sdata})
      $display("FAIL label_wr got %b %h/%h/%h want %b %h/%h/%h", ctl(), st_write_layer,
               st_write_row, st_write_data, e, m_layer, m_row, m_sdata);
    else n_pass++;
  endtask

  task automatic test_random_writes();
    logic [10:0] e;
    logic [2:0]  t;
    bit          v;
    int          k;
    for (int i = 0; i < 40; i++) begin
      k = int'($urandom_range(0, 6));
      t = (k < 4) ? 3'(k) : 3'(k + 1);
      v = ($urandom_range(0, 3) != 0);
      drive(v, t, $urandom(), (t == 3'd0) ? IDX_W'($urandom_range(0, 7)) : $urandom(),
            DATA_W'({$urandom(), $urandom()}));
      e = model_idle(v, t, cmd_layer, cmd_row, cmd_data);
      tick();
      n_checks++;
      if (ctl() !== e || {code_write_line, code_write_data} !== {m_line, m_cdata}
          || {st_write_layer, st_write_row, st_write_data} !== {m_layer, m_row, m_sdata})
        $display("FAIL rand_wr%0d got %b %h %h want %b %h %h", i, ctl(), code_write_line,
                 st_write_row, e, m_line, m_row);
      else n_pass++;
    end
    cmd_valid = 1'b0;
  endtask

  // Start a run and follow it cycle by cycle; mode picks the code_index pattern.
  task automatic do_run(input int mode, input bit hold, input string name);
    logic [IDX_W-1:0]  idx, hl, hr;
    logic [DATA_W-1:0] hd;
    logic [10:0]       e;
    bit                ended;
    drive(1'b1, 3'd4, '0, '0, '0);
    code_index = '0;
    tick();
    m_error = 1'b0;
    hl = $urandom(); hr = $urandom(); hd = DATA_W'({$urandom(), $urandom()});
    drive(hold, 3'd1, hl, hr, hd);
    for (int i = 0; i < int'(LRST); i++) begin
      n_checks++;
      if (ctl() !== 11'h00C) $display("FAIL %s lrst%0d got %b want %b", name, i, ctl(), 11'h00C);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (ctl() !== 11'h024) $display("FAIL %s arm got %b want %b", name, ctl(), 11'h024);
    else n_pass++;
    tick();
    ended = 1'b0;
    for (int c = 1; c <= WD_MAX; c++) begin
      n_checks++;
      if (ctl() !== 11'h034) $display("FAIL %s run%0d got %b want %b", name, c, ctl(), 11'h034);
      else n_pass++;
      case (mode)
        0:       idx = IDX_W'(c - 1);
        1:       idx = '0;
        2:       idx = IDX_W'($urandom_range(0, 2 * int'(m_code_count)));
        default: idx = '1;
      endcase
      code_index = idx;
      ended = (64'(idx) >= m_code_count);
      tick();
      if (ended) break;
    end
    if (!ended) m_error = 1'b1;
    e = {1'b1, 8'b0, ended, m_error};
    n_checks++;
    if ((ctl() | 11'h004) !== (e | 11'h004))
      $display("FAIL %s end got %b want %b", name, ctl(), e);
    else n_pass++;
    e = model_idle(hold, 3'd1, hl, hr, hd);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (ctl() !== e || {st_write_layer, st_write_row, st_write_data} !== {m_layer, m_row, m_sdata})
      $display("FAIL %s after got %b %h want %b %h", name, ctl(), st_write_row, e, m_row);
    else n_pass++;
  endtask

  task automatic test_run_normal();
    do_run(0, 1'b0, "run_seq");
  endtask

  task automatic test_timeout();
    do_run(1, 1'b1, "run_timeout");
  endtask

  task automatic test_random_run();
    logic [10:0] e;
    if (m_code_count == 0) begin
      drive(1'b1, 3'd0, '0, IDX_W'($urandom_range(0, 5)), '0);
      e = model_idle(1'b1, 3'd0, cmd_layer, cmd_row, cmd_data);
      tick();
      cmd_valid = 1'b0;
      n_checks++;
      if (ctl() !== e) $display("FAIL rand_run_load got %b want %b", ctl(), e);
      else n_pass++;
    end
    for (int r = 0; r < 3; r++) do_run(2, r[0], "run_rand");
  endtask

  task automatic test_no_code();
    logic [10:0] e;
    apply_reset();
    drive(1'b1, 3'd4, '0, '0, '0);
    e = model_idle(1'b1, 3'd4, '0, '0, '0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ctl() !== e) $display("FAIL nocode%0d got %b want %b", i, ctl(), e);
      else n_pass++;
      e = model_idle(1'b0, 3'd0, '0, '0, '0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'd0, '0, IDX_W'($urandom_range(0, 5)), DATA_W'($urandom()));
      e = model_idle(1'b1, 3'd0, cmd_layer, cmd_row, cmd_data);
      tick();
    end
    cmd_valid = 1'b0;
    do_run(2, 1'b0, "nocode_restart");
  endtask

  task automatic test_wide_line();
    logic [10:0] e;
    apply_reset();
    drive(1'b1, 3'd0, '0, '1, DATA_W'($urandom()));
    e = model_idle(1'b1, 3'd0, cmd_layer, cmd_row, cmd_data);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (ctl() !== e || code_write_line !== m_line)
      $display("FAIL wide_wr got %b %h want %b %h", ctl(), code_write_line, e, m_line);
    else n_pass++;
    do_run(3, 1'b0, "wide_line");
  endtask

  task automatic test_reset_midrun();
    logic [10:0] e;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, '0, IDX_W'(i), DATA_W'($urandom()));
      e = model_idle(1'b1, 3'd0, cmd_layer, cmd_row, cmd_data);
      tick();
    end
    drive(1'b1, 3'd4, '0, '0, '0);
    code_index = '0;
    tick();
    cmd_valid = 1'b0;
    repeat (LRST + 2) tick();
    n_checks++;
    if (ctl() !== 11'h034) $display("FAIL midrun_pre got %b want %b", ctl(), 11'h034);
    else n_pass++;
    #3;
    reset_reset_n = 1'b0;
    #1;
    n_checks++;
    if (ctl() !== 11'h400) $display("FAIL midrun_async got %b want %b", ctl(), 11'h400);
    else n_pass++;
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    model_reset();
    tick();
    n_checks++;
    if (ctl() !== 11'h400) $display("FAIL midrun_release got %b want %b", ctl(), 11'h400);
    else n_pass++;
    drive(1'b1, 3'd4, '0, '0, '0);
    e = model_idle(1'b1, 3'd4, '0, '0, '0);
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (ctl() !== e) $display("FAIL midrun_restart got %b want %b", ctl(), e);
    else n_pass++;
  endtask

  initial begin
    reset_reset_n = 1'b0;
    drive(1'b0, 3'd0, '0, '0, '0);
    code_index = '0;
    model_reset();
    test_reset();
    test_code_writes();
    test_weight_label();
    test_run_normal();
    test_timeout();
    test_random_writes();
    test_random_run();
    test_no_code();
    test_wide_line();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/storage_load_sequencer.md
Name: storage_load_sequencer

Overview:
Host-side loader and run sequencer in front of data_path. Accepts a valid/ready command stream and turns each command into a single-cycle write on the code, weight, input or label storage port. On a start command it pulses the matrix storage locator reset, arms code storage, then enables the controller. It watches the fetch code index to end the run, with a watchdog as backstop.

Parameters:
DATA_W, 48, storage row width (three 16-bit fixed-point values)
CODE_W, 12, instruction width
IDX_W, 32, layer/row/line/code-index width
LOC_RESET_CYCLES, 2, cycles matrix_reset is held high before arming (>=1)
WATCHDOG_W, 16, watchdog counter width; timeout at all-ones

Ports:
clk_clk  in  1  clock
reset_reset_n  in  1  async active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_target  in  3  0 code, 1 weight, 2 input, 3 label, 4 start, 5-7 illegal
cmd_layer  in  IDX_W  layer index (weight/input/label)
cmd_row  in  IDX_W  row index; code line for target 0
cmd_data  in  DATA_W  row data; code uses [CODE_W-1:0]
code_index  in  IDX_W  fetch_to_decode code index from data_path
code_is_write  out  1  code storage write strobe
code_write_line  out  IDX_W  code line
code_write_data  out  CODE_W  instruction
wt_is_write, in_is_write, lb_is_write  out  1 each  storage write strobes
st_write_layer  out  IDX_W  shared layer index
st_write_row  out  IDX_W  shared row index
st_write_data  out  DATA_W  shared row data
code_storage_enable  out  1  code storage enable
controller_enable  out  1  controller enable
matrix_reset  out  1  matrix storage locator reset
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at normal run end
error  out  1  sticky; cleared only by reset or an accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except cmd_ready=1. code_count=0, watchdog=0.
- All outputs are registered.
- IDLE: cmd_ready=1. A write command (target 0-3) accepted at cycle N gives exactly one strobe at cycle N+1, with line/layer/row/data registered from the command.
- Back-to-back writes sustain one per cycle. Strobes are one-hot. Non-strobed data outputs hold their last value.
- Code write: code_count <= max(code_count, cmd_row+1).
- Illegal target (5-7): consumed, no strobe, error<=1.
- Start (target 4): accepted in IDLE; clears error.
  - If code_count==0: error<=1, stay IDLE, no enables.
  - Otherwise go to LRST.
- LRST: cmd_ready=0, matrix_reset=1 for exactly LOC_RESET_CYCLES cycles, then ARM.
- ARM: one cycle with code_storage_enable=1 and controller_enable=0. The controller therefore sees one cycle of valid fetch before enable. Then RUN.
- RUN: code_storage_enable=1, controller_enable=1, cmd_ready=0, watchdog increments every cycle.
  - Normal end: code_index >= code_count (unsigned) gives done=1 for one cycle. Both enables drop in that same cycle, then IDLE.
  - Timeout: watchdog all-ones before normal end gives error=1, enables drop, no done, then IDLE.
  - If end and timeout fall in the same cycle, normal end wins.
- Watchdog clears on entering ARM.
- cmd_valid while busy: ignored, not consumed. The command stays pending until IDLE.
- Reset asserted mid-run: all enables and strobes drop immediately (asynchronous). code_count is lost; the host reloads the program.
- The start command itself produces no strobe.

Decomposition:
- Package storage_load_pkg: target encodings (TGT_CODE..TGT_START), state enum (IDLE, LRST, ARM, RUN), default widths.
- One sub-module, seq_watchdog: counter with clear, enable and terminal-count output. All other logic lives in the top FSM.

Test Plan:
- Reset, then write code lines 0..3 back-to-back: 4 consecutive code_is_write pulses, each 1 cycle after acceptance, lines 0..3; code_count=4; cmd_ready stays 1.
- Weight write layer 1 row 2 data 48'h0001_0002_0003, then label write layer 0 row 5: wt_is_write then lb_is_write on consecutive cycles with matching layer/row/data; in/code strobes stay 0.
- Start after 4 code lines, code_index driven 0,1,2,3,4:
  - matrix_reset high 2 cycles;
  - then 1 cycle code_storage_enable=1 with controller_enable=0;
  - then both enables high;
  - done pulses when code_index=4, enables drop that cycle, busy returns 0 next cycle.
- Start with no code loaded: error=1, matrix_reset never asserts, busy stays 0. A later valid start clears error.
- Run with code_index stuck at 0 and WATCHDOG_W=4: after 15 RUN cycles error=1, enables drop, done never pulses. A command held valid during the run is accepted on the first IDLE cycle.
- Assert reset_reset_n=0 mid-RUN between clock edges: controller_enable, code_storage_enable and busy go 0 without waiting for a clock. After release, cmd_ready=1 and a start with no reload raises error.
